// File: rtl/mem_stage_pkg.sv
// Shared types for the multi-entry memory stage: load-op bit positions, exception flag width,
// per-slot control struct and the load extraction helper.
package mem_stage_pkg;

    localparam int LDOP_W    = 5;
    localparam int EX_FLAG_W = 7;

    // ld_op is {ld_b, ld_bu, ld_h, ld_hu, ld_w}
    localparam int LD_W_BIT  = 0;
    localparam int LD_HU_BIT = 1;
    localparam int LD_H_BIT  = 2;
    localparam int LD_BU_BIT = 3;
    localparam int LD_B_BIT  = 4;

    typedef struct packed {
        logic              rf_we;
        logic [4:0]        waddr;
        logic [LDOP_W-1:0] ld_op;
        logic              wait_rsp;
    } slot_ctrl_t;

    function automatic logic [31:0] ld_extract(input logic [31:0]       rdata,
                                               input logic [1:0]        offset,
                                               input logic [LDOP_W-1:0] ld_op);
        logic [31:0] shifted;
        shifted    = rdata >> {offset, 3'b000};
        ld_extract = shifted;
        if (ld_op[LD_B_BIT]) begin
            ld_extract = {{24{shifted[7]}}, shifted[7:0]};
        end else if (ld_op[LD_BU_BIT]) begin
            ld_extract = {24'b0, shifted[7:0]};
        end else if (ld_op[LD_H_BIT]) begin
            ld_extract = {{16{shifted[15]}}, shifted[15:0]};
        end else if (ld_op[LD_HU_BIT]) begin
            ld_extract = {16'b0, shifted[15:0]};
        end
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load data alignment: shifts the bus word by the byte offset and
// sign/zero-extends according to the one-hot load opcode.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0]       rdata,
    input  logic [1:0]        offset,
    input  logic [LDOP_W-1:0] ld_op,
    output logic [31:0]       word
);

    assign word = ld_extract(rdata, offset, ld_op);

endmodule

// File: rtl/mem_stage_mq.sv
// Multi-entry EX->WB memory stage: in-order ring of DEPTH slots, in-order data_ok matching,
// head load alignment and flush-time discard of owed responses. Optional macro MEM_STAGE_MQ_FWD_EN.
module mem_stage_mq
    import mem_stage_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter int  XLEN  = 32,
    parameter int  EXZ_W = 86,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  es_to_ms_valid,
    output logic                  ms_allowin,
    input  logic [XLEN-1:0]       es_pc,
    input  logic [XLEN-1:0]       es_result,
    input  logic                  es_rf_we,
    input  logic [4:0]            es_rf_waddr,
    input  logic [LDOP_W-1:0]     es_ld_op,
    input  logic                  es_mem_req,
    input  logic [EXZ_W-1:0]      es_ex_zip,
    input  logic                  ws_allowin,
    output logic                  ms_to_ws_valid,
    output logic [XLEN-1:0]       ms_pc,
    output logic                  ms_rf_we,
    output logic [4:0]            ms_rf_waddr,
    output logic [XLEN-1:0]       ms_rf_wdata,
    output logic [EXZ_W-1:0]      ms_ex_zip,
    output logic                  ms_ex,
    input  logic                  data_sram_data_ok,
    input  logic [XLEN-1:0]       data_sram_rdata,
    input  logic                  wb_ex,
    output logic                  ms_discarding
`ifdef MEM_STAGE_MQ_FWD_EN
    ,
    output logic [DEPTH-1:0]      fwd_valid,
    output logic [DEPTH*5-1:0]    fwd_waddr,
    output logic [DEPTH*XLEN-1:0] fwd_wdata,
    output logic [DEPTH-1:0]      fwd_pending
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] slot_valid;
    slot_ctrl_t       slot_ctrl   [DEPTH];
    logic [XLEN-1:0]  slot_pc     [DEPTH];
    logic [XLEN-1:0]  slot_result [DEPTH];
    logic [XLEN-1:0]  slot_rdata  [DEPTH];
    logic [EXZ_W-1:0] slot_exz    [DEPTH];

    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W-1:0] resp_ptr;
    logic [CNT_W-1:0] occupancy;
    logic [CNT_W-1:0] discard_cnt;
    logic [CNT_W-1:0] n_wait;

    logic resp_hit;
    logic any_ex;
    logic head_valid;
    logic full;
    logic enq;
    logic deq;
    logic rsp_take;
    logic rsp_drop;
    logic flush_dec;
    logic [31:0] head_ld_word;

    // Walk slots oldest-first: the first waiting slot owns the next data_ok.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx      = head_ptr;
        resp_hit = 1'b0;
        resp_ptr = head_ptr;
        n_wait   = '0;
        any_ex   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_ptr + PTR_W'(i);
            if (slot_valid[idx] && slot_ctrl[idx].wait_rsp) begin
                n_wait = n_wait + CNT_W'(1);
                if (!resp_hit) begin
                    resp_hit = 1'b1;
                    resp_ptr = idx;
                end
            end
            if (slot_valid[i] && (|slot_exz[i][EX_FLAG_W-1:0])) begin
                any_ex = 1'b1;
            end
        end
    end

    // Handshakes: a transfer occurs on a clock edge where valid and the receiver's allowin are
    // both high; valid never depends on the receiver's allowin.
    assign head_valid     = slot_valid[head_ptr];
    assign ms_to_ws_valid = head_valid & ~slot_ctrl[head_ptr].wait_rsp & ~wb_ex;
    assign full           = (occupancy == CNT_W'(DEPTH));
    assign ms_allowin     = ~full | (ms_to_ws_valid & ws_allowin);
    assign enq            = es_to_ms_valid & ms_allowin & ~wb_ex;
    assign deq            = ms_to_ws_valid & ws_allowin;
    assign rsp_take       = data_sram_data_ok & (discard_cnt == '0) & resp_hit;
    assign rsp_drop       = data_sram_data_ok & (discard_cnt != '0);
    // A response arriving on the flush edge still consumes one owed response.
    assign flush_dec      = data_sram_data_ok & ((discard_cnt != '0) | resp_hit);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            slot_valid  <= '0;
            head_ptr    <= '0;
            tail_ptr    <= '0;
            occupancy   <= '0;
            discard_cnt <= '0;
        end else if (wb_ex) begin
            slot_valid  <= '0;
            head_ptr    <= '0;
            tail_ptr    <= '0;
            occupancy   <= '0;
            discard_cnt <= discard_cnt + n_wait - CNT_W'(flush_dec);
        end else begin
            if (rsp_drop) begin
                discard_cnt <= discard_cnt - CNT_W'(1);
            end
            if (deq) begin
                slot_valid[head_ptr] <= 1'b0;
                head_ptr             <= head_ptr + PTR_W'(1);
            end
            if (enq) begin
                slot_valid[tail_ptr] <= 1'b1;
                tail_ptr             <= tail_ptr + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Payload needs no reset: every output path is masked by slot_valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            slot_pc[tail_ptr]     <= es_pc;
            slot_result[tail_ptr] <= es_result;
            slot_exz[tail_ptr]    <= es_ex_zip;
            slot_ctrl[tail_ptr]   <= '{rf_we: es_rf_we, waddr: es_rf_waddr,
                                       ld_op: es_ld_op, wait_rsp: es_mem_req};
        end
        if (rsp_take) begin
            slot_rdata[resp_ptr]         <= data_sram_rdata;
            slot_ctrl[resp_ptr].wait_rsp <= 1'b0;
        end
    end

    mem_load_align u_load_align (
        .rdata  (slot_rdata[head_ptr]),
        .offset (slot_result[head_ptr][1:0]),
        .ld_op  (slot_ctrl[head_ptr].ld_op),
        .word   (head_ld_word)
    );

    assign ms_pc         = head_valid ? slot_pc[head_ptr] : '0;
    assign ms_rf_we      = ms_to_ws_valid & slot_ctrl[head_ptr].rf_we;
    assign ms_rf_waddr   = head_valid ? slot_ctrl[head_ptr].waddr : 5'd0;
    assign ms_rf_wdata   = !head_valid ? '0 :
                           (|slot_ctrl[head_ptr].ld_op) ? head_ld_word : slot_result[head_ptr];
    assign ms_ex_zip     = head_valid ? slot_exz[head_ptr] : '0;
    assign ms_ex         = any_ex;
    assign ms_discarding = (discard_cnt != '0);

`ifdef MEM_STAGE_MQ_FWD_EN
    // Age-ordered bypass view: entry 0 is the head slot.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx         = head_ptr;
        fwd_valid   = '0;
        fwd_waddr   = '0;
        fwd_wdata   = '0;
        fwd_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx                     = head_ptr + PTR_W'(i);
            fwd_valid[i]            = slot_valid[idx] & slot_ctrl[idx].rf_we;
            fwd_waddr[i*5 +: 5]     = slot_ctrl[idx].waddr;
            fwd_wdata[i*XLEN +: XLEN] = (|slot_ctrl[idx].ld_op) ?
                ld_extract(slot_rdata[idx], slot_result[idx][1:0], slot_ctrl[idx].ld_op) :
                slot_result[idx];
            fwd_pending[i]          = slot_valid[idx] & slot_ctrl[idx].wait_rsp &
                                      (|slot_ctrl[idx].ld_op);
        end
    end
`endif

    always @(posedge clk) begin
        if (resetn) begin
            assert (!(data_sram_data_ok && (discard_cnt == '0) && !resp_hit));
            assert (discard_cnt <= CNT_W'(DEPTH));
        end
    end

endmodule

// File: tb/tb_mem_stage_mq.sv
// Directed bench for mem_stage_mq: enqueued instructions push expected retire records,
// the retire monitor pops and compares them in program order.
module tb_mem_stage_mq;

    localparam int DEPTH = 2;
    localparam int XLEN  = 32;
    localparam int EXZ_W = 86;
    localparam int W     = 70;

    localparam logic [4:0] OP_W  = 5'b00001;
    localparam logic [4:0] OP_HU = 5'b00010;
    localparam logic [4:0] OP_H  = 5'b00100;
    localparam logic [4:0] OP_BU = 5'b01000;
    localparam logic [4:0] OP_B  = 5'b10000;
    localparam logic [4:0] OP_NONE = 5'b00000;

    logic             clk;
    logic             resetn;
    logic             es_to_ms_valid;
    logic             ms_allowin;
    logic [XLEN-1:0]  es_pc;
    logic [XLEN-1:0]  es_result;
    logic             es_rf_we;
    logic [4:0]       es_rf_waddr;
    logic [4:0]       es_ld_op;
    logic             es_mem_req;
    logic [EXZ_W-1:0] es_ex_zip;
    logic             ws_allowin;
    logic             ms_to_ws_valid;
    logic [XLEN-1:0]  ms_pc;
    logic             ms_rf_we;
    logic [4:0]       ms_rf_waddr;
    logic [XLEN-1:0]  ms_rf_wdata;
    logic [EXZ_W-1:0] ms_ex_zip;
    logic             ms_ex;
    logic             data_sram_data_ok;
    logic [XLEN-1:0]  data_sram_rdata;
    logic             wb_ex;
    logic             ms_discarding;
`ifdef MEM_STAGE_MQ_FWD_EN
    logic [DEPTH-1:0]      fwd_valid;
    logic [DEPTH*5-1:0]    fwd_waddr;
    logic [DEPTH*XLEN-1:0] fwd_wdata;
    logic [DEPTH-1:0]      fwd_pending;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    mem_stage_mq #(.DEPTH(DEPTH), .XLEN(XLEN), .EXZ_W(EXZ_W)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .es_to_ms_valid    (es_to_ms_valid),
        .ms_allowin        (ms_allowin),
        .es_pc             (es_pc),
        .es_result         (es_result),
        .es_rf_we          (es_rf_we),
        .es_rf_waddr       (es_rf_waddr),
        .es_ld_op          (es_ld_op),
        .es_mem_req        (es_mem_req),
        .es_ex_zip         (es_ex_zip),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_pc             (ms_pc),
        .ms_rf_we          (ms_rf_we),
        .ms_rf_waddr       (ms_rf_waddr),
        .ms_rf_wdata       (ms_rf_wdata),
        .ms_ex_zip         (ms_ex_zip),
        .ms_ex             (ms_ex),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .wb_ex             (wb_ex),
        .ms_discarding     (ms_discarding)
`ifdef MEM_STAGE_MQ_FWD_EN
        ,
        .fwd_valid         (fwd_valid),
        .fwd_waddr         (fwd_waddr),
        .fwd_wdata         (fwd_wdata),
        .fwd_pending       (fwd_pending)
`endif
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference load extraction, written by byte/halfword selection.
    function automatic logic [31:0] ref_ld(input logic [31:0] rd, input logic [1:0] off,
                                           input logic [4:0] op);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = off[1] ? rd[31:16] : rd[15:0];
        case (op)
            OP_B:    ref_ld = {{24{b[7]}}, b};
            OP_BU:   ref_ld = {24'h0, b};
            OP_H:    ref_ld = {{16{h[15]}}, h};
            OP_HU:   ref_ld = {16'h0, h};
            OP_W:    ref_ld = rd;
            default: ref_ld = 32'h0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every retire handshake pops one expected record.
    always @(negedge clk) begin
        if (resetn === 1'b1 && ms_to_ws_valid === 1'b1 && ws_allowin === 1'b1) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL retire_unexpected observed pc=%h expected no retire", ms_pc);
            end
            if (exp_q.size() != 0) begin
                check("retire", 96'({ms_pc, ms_rf_waddr, ms_rf_we, ms_rf_wdata}),
                      96'(exp_q.pop_front()));
            end
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [31:0] pc, input logic [31:0] res, input logic we,
                       input logic [4:0] wa, input logic [4:0] op, input logic mr,
                       input logic [EXZ_W-1:0] exz, input logic [31:0] ewd);
        int n;
        n              = 0;
        es_to_ms_valid = 1'b1;
        es_pc          = pc;
        es_result      = res;
        es_rf_we       = we;
        es_rf_waddr    = wa;
        es_ld_op       = op;
        es_mem_req     = mr;
        es_ex_zip      = exz;
        #1;
        while (ms_allowin !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("enq_allowin", 96'(ms_allowin), 96'(1));
        exp_q.push_back({pc, wa, we, ewd});
        step();
        es_to_ms_valid = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rd, input int cycles);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rd;
        repeat (cycles) step();
        data_sram_data_ok = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        check("drain_empty", 96'(exp_q.size()), 96'(0));
    endtask

    initial begin
        logic [31:0] rd;
        resetn            = 1'b0;
        es_to_ms_valid    = 1'b0;
        es_pc             = '0;
        es_result         = '0;
        es_rf_we          = 1'b0;
        es_rf_waddr       = '0;
        es_ld_op          = '0;
        es_mem_req        = 1'b0;
        es_ex_zip         = '0;
        ws_allowin        = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        wb_ex             = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_allowin",   96'(ms_allowin),     96'(1));
        check("rst_to_ws",     96'(ms_to_ws_valid), 96'(0));
        check("rst_ex",        96'(ms_ex),          96'(0));
        check("rst_discard",   96'(ms_discarding),  96'(0));
        check("rst_pc",        96'(ms_pc),          96'(0));
        check("rst_wdata",     96'(ms_rf_wdata),    96'(0));
        check("rst_exzip",     96'(ms_ex_zip),      96'(0));
        resetn = 1'b1;
        step();

        // Non-memory instruction is ready the cycle after enqueue
        enq(32'h0000_1800, 32'h0000_0055, 1'b1, 5'd3, OP_NONE, 1'b0, '0, 32'h0000_0055);
        check("alu_latency", 96'(ms_to_ws_valid), 96'(1));
        check("alu_wdata",   96'(ms_rf_wdata),    96'(32'h55));
        drain();

        // Back-to-back ld_w then ld_b offset 3, responses 2 and 3 cycles after the first
        rd = 32'h80FF_FF12;
        enq(32'h0000_1000, 32'h0000_0100, 1'b1, 5'd5, OP_W, 1'b1, '0, ref_ld(rd, 2'd0, OP_W));
        enq(32'h0000_1004, 32'h0000_0103, 1'b1, 5'd6, OP_B, 1'b1, '0, ref_ld(rd, 2'd3, OP_B));
        respond(rd, 2);
        drain();

        // ALU op behind a waiting load stays put
        rd = 32'hCAFE_BABE;
        enq(32'h0000_2000, 32'h0000_0200, 1'b1, 5'd7, OP_W, 1'b1, '0, ref_ld(rd, 2'd0, OP_W));
        enq(32'h0000_2004, 32'h0000_1234, 1'b1, 5'd8, OP_NONE, 1'b0, '0, 32'h0000_1234);
        repeat (3) begin
            check("add_held",       96'(ms_to_ws_valid), 96'(0));
            check("full_wait_allow", 96'(ms_allowin),    96'(0));
            step();
        end
        respond(rd, 1);
        drain();

        // Full with WB stalled, then enqueue and dequeue on the same edge
        ws_allowin = 1'b0;
        rd = 32'hABCD_F00F;
        enq(32'h0000_3000, 32'h0000_0300, 1'b1, 5'd9, OP_H, 1'b1, '0, ref_ld(rd, 2'd0, OP_H));
        enq(32'h0000_3004, 32'h0000_0302, 1'b1, 5'd10, OP_HU, 1'b1, '0, ref_ld(rd, 2'd2, OP_HU));
        respond(rd, 2);
        check("full_stall_allowin", 96'(ms_allowin),     96'(0));
        check("full_stall_valid",   96'(ms_to_ws_valid), 96'(1));
        ws_allowin = 1'b1;
        #1;
        check("full_deq_allowin", 96'(ms_allowin), 96'(1));
        enq(32'h0000_3008, 32'h0000_0077, 1'b1, 5'd11, OP_NONE, 1'b0, '0, 32'h0000_0077);
        drain();

        // Flush with two loads waiting: two owed responses discarded
        rd = 32'h0000_8001;
        enq(32'h0000_4000, 32'h0000_0400, 1'b1, 5'd12, OP_W, 1'b1, '0, 32'h0);
        enq(32'h0000_4004, 32'h0000_0404, 1'b1, 5'd13, OP_W, 1'b1, '0, 32'h0);
        wb_ex = 1'b1;
        exp_q.delete();
        step();
        wb_ex = 1'b0;
        check("flush_discarding", 96'(ms_discarding),  96'(1));
        check("flush_to_ws",      96'(ms_to_ws_valid), 96'(0));
        check("flush_allowin",    96'(ms_allowin),     96'(1));
        check("flush_pc",         96'(ms_pc),          96'(0));
        enq(32'h0000_4010, 32'h0000_0400, 1'b1, 5'd14, OP_HU, 1'b1, '0, ref_ld(rd, 2'd0, OP_HU));
        respond(32'hDEAD_DEAD, 1);
        check("discard1_flag",  96'(ms_discarding),  96'(1));
        check("discard1_valid", 96'(ms_to_ws_valid), 96'(0));
        respond(32'hDEAD_DEAD, 1);
        check("discard2_flag",  96'(ms_discarding),  96'(0));
        check("discard2_valid", 96'(ms_to_ws_valid), 96'(0));
        respond(rd, 1);
        drain();

        // Flush coincident with a response: only one owed response remains
        enq(32'h0000_5000, 32'h0000_0500, 1'b1, 5'd15, OP_W, 1'b1, '0, 32'h0);
        enq(32'h0000_5004, 32'h0000_0504, 1'b1, 5'd16, OP_W, 1'b1, '0, 32'h0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1111_1111;
        wb_ex             = 1'b1;
        exp_q.delete();
        step();
        data_sram_data_ok = 1'b0;
        wb_ex             = 1'b0;
        check("coinc_discarding", 96'(ms_discarding), 96'(1));
        respond(32'h2222_2222, 1);
        check("coinc_drained", 96'(ms_discarding),  96'(0));
        check("coinc_to_ws",   96'(ms_to_ws_valid), 96'(0));

        // Exception-carrying head held by WB, then reset mid-operation
        ws_allowin = 1'b0;
        enq(32'h0000_6000, 32'h0000_0001, 1'b1, 5'd17, OP_NONE, 1'b0, EXZ_W'(1), 32'h1);
        check("ex_flag",  96'(ms_ex),     96'(1));
        check("ex_zip",   96'(ms_ex_zip), 96'(1));
        step();
        check("ex_held",       96'(ms_ex),          96'(1));
        check("ex_held_valid", 96'(ms_to_ws_valid), 96'(1));
        resetn = 1'b0;
        exp_q.delete();
        step();
        check("midrst_ex",      96'(ms_ex),          96'(0));
        check("midrst_to_ws",   96'(ms_to_ws_valid), 96'(0));
        check("midrst_allowin", 96'(ms_allowin),     96'(1));
        check("midrst_pc",      96'(ms_pc),          96'(0));
        check("midrst_discard", 96'(ms_discarding),  96'(0));
        resetn     = 1'b1;
        ws_allowin = 1'b1;
        step();

        // Operation resumes after reset
        enq(32'h0000_7000, 32'h0000_0099, 1'b1, 5'd18, OP_NONE, 1'b0, '0, 32'h0000_0099);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
